pps_select_v3: RTL and testbench
================================

// Module: pps_select_v3
// PURPOSE
//  Parametrised successor to the fixed three-input PPS block. Takes NUM_PPS asynchronous
//  GPS PPS inputs, synchronises and debounces each, and watchdogs each for a missing pulse.
//  It auto-fails-over between sources, then drives the PPS and PPS_BURST outputs.
//  It sits on pclk behind the TURFIO register decoder and is accessed through one 32-bit register.
// PARAMETERS
//  NUM_PPS         3          number of PPS inputs, 1..8
//  TIMEOUT_CYCLES  50000000   cycles without an accepted edge before an input is flagged missing
//  HOLDOFF_CYCLES  1000000    edges on an input are ignored for this many cycles after an accepted edge
//  PPS_WIDTH       16         pps_o high time in cycles, >=1
//  BURST_PULSES    8          pulses per burst on pps_burst_o, >=1
//  BURST_HIGH      4          burst pulse high cycles, >=1
//  BURST_LOW       4          burst pulse low cycles, >=1
// PORTS
//  clk_i        in   1        pclk; all logic is on this clock
//  rst_i        in   1        asynchronous reset, active-high
//  wr_i         in   1        register write strobe, one cycle
//  dat_i        in   32       write data
//  dat_o        out  32       read data (combinational from registers)
//  pps_in_i     in   NUM_PPS  raw PPS inputs, asynchronous to clk_i
//  pps_o        out  1        selected PPS pulse
//  pps_burst_o  out  1        burst train following each PPS
// BEHAVIOUR
//  Register write: [3:0] src_sel; [4] autofail_en; [5] sw_pps strobe (self-clearing); [6] clear pps_count.
//  Register read: [3:0] src_sel; [4] autofail_en; [11:8] active_src; [23:16] missing[NUM_PPS-1:0]
//  (unused bits read 0); [31:24] pps_count.
//  Reset: every output 0, src_sel=0, autofail_en=0, active_src=0, missing=0, pps_count=0, all counters 0.
//  Input path: each input goes through a 2-FF synchroniser and a registered rising-edge detect.
//   An input rising edge yields edge[k] 3 clocks later.
//   An edge is accepted only if the holdoff counter of that input is 0.
//   Acceptance loads the holdoff counter with HOLDOFF_CYCLES-1, which then counts down to 0.
//  Watchdog per input:
//   - counter clears on an accepted edge, else increments and saturates at TIMEOUT_CYCLES.
//   - missing[k] sets the cycle the counter reaches TIMEOUT_CYCLES.
//   - missing[k] clears on the next accepted edge of that input.
//  Source selection, registered, updated every cycle:
//   - autofail_en=0: active_src=src_sel.
//   - autofail_en=1, src_sel valid and not missing: active_src=src_sel (revert has priority).
//   - otherwise: active_src = lowest-index non-missing input.
//   - all inputs missing: active_src holds its value.
//   - src_sel>=NUM_PPS with autofail_en=0: no external source is used; only sw_pps fires pps_o.
//  Trigger = accepted edge of active_src OR sw_pps write.
//   Both in the same cycle produce one trigger, and pps_count increments by 1.
//  pps_o rises the cycle after the trigger and stays high exactly PPS_WIDTH cycles.
//   A trigger while pps_o is high is ignored entirely: no retrigger, no count.
//  pps_count is an 8-bit counter, +1 per pps_o rising edge, wrapping 255->0.
//   A clear write wins over a simultaneous increment.
//  Burst FSM, states IDLE, HIGH, LOW:
//   - IDLE -> HIGH on each pps_o rising edge; the pulse counter is loaded with BURST_PULSES.
//   - HIGH holds BURST_HIGH cycles; pps_burst_o=1 only in HIGH.
//   - HIGH -> LOW; LOW holds BURST_LOW cycles, then the pulse counter decrements.
//   - LOW -> HIGH if pulses remain, otherwise -> IDLE.
//   - A new pps_o rise mid-burst restarts at HIGH with the counter reloaded.
//  Asserting rst_i mid-pulse or mid-burst forces pps_o=0, pps_burst_o=0 and the FSM to IDLE immediately.
// TESTING (NUM_PPS=3, TIMEOUT=100, HOLDOFF=10, PPS_WIDTH=4, BURST 3/2/2)
//  1 Input 0 edge, src_sel=0 -> pps_o high 4 cycles starting cycle 4 after the edge;
//    burst gives 3 pulses of 2 high/2 low; pps_count=1.
//  2 A second input 0 edge 5 cycles after the first -> ignored (holdoff); pps_count stays 1.
//  3 autofail_en=1; input 0 silent for 100 cycles while input 2 pulses -> missing[0]=1,
//    active_src=2 the next cycle; input 2 edges drive pps_o. Input 0 edge -> active_src back to 0.
//  4 sw_pps write in the same cycle as an accepted input edge -> one 4-cycle pps_o; pps_count +1.
//  5 Drive 256 PPS -> pps_count reads 0. Clear write coinciding with a trigger -> reads 0.
//  6 Assert rst_i during burst pulse 2 -> pps_o=0, pps_burst_o=0, register reads 0x00000000.

Source files
------------

// File: rtl/pps_select_v3.sv
// PPS source selector: per-input sync/debounce/watchdog lanes, auto-failover,
// fixed-width pps_o pulse with a follow-on burst train, one 32-bit control register.

module pps_select_v3_lane #(
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int HOLDOFF_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pps,
  output logic o_acc,
  output logic o_miss
);
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HOW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WD_PRE  = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [HOW-1:0] HOLD_LD = HOW'(HOLDOFF_CYCLES - 1);

  logic           r_s1, r_s2, r_s3, r_edge, r_miss;
  logic [WDW-1:0] r_wd;
  logic [HOW-1:0] r_hold;
  logic           w_acc;

  assign w_acc  = r_edge && (r_hold == '0);
  assign o_acc  = w_acc;
  assign o_miss = r_miss;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_edge <= 1'b0;
      r_miss <= 1'b0;
      r_wd   <= '0;
      r_hold <= '0;
    end else begin
      r_s1   <= i_pps;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_edge <= r_s2 & ~r_s3;
      if (w_acc)              r_hold <= HOLD_LD;
      else if (r_hold != '0)  r_hold <= r_hold - 1'b1;
      // missing flags on the same cycle the watchdog saturates
      if (w_acc) begin
        r_wd   <= '0;
        r_miss <= 1'b0;
      end else if (r_wd != WD_MAX) begin
        r_wd <= r_wd + 1'b1;
        if (r_wd == WD_PRE) r_miss <= 1'b1;
      end
    end
  end
endmodule

module pps_select_v3 #(
  parameter int NUM_PPS        = 3,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int HOLDOFF_CYCLES = 1000000,
  parameter int PPS_WIDTH      = 16,
  parameter int BURST_PULSES   = 8,
  parameter int BURST_HIGH     = 4,
  parameter int BURST_LOW      = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_i,
  input  logic [31:0]        dat_i,
  output logic [31:0]        dat_o,
  input  logic [NUM_PPS-1:0] pps_in_i,
  output logic               pps_o,
  output logic               pps_burst_o
);
  localparam int PWW  = $clog2(PPS_WIDTH + 1);
  localparam int BPW  = $clog2(BURST_PULSES + 1);
  localparam int BMAX = (BURST_HIGH > BURST_LOW) ? BURST_HIGH : BURST_LOW;
  localparam int BHW  = $clog2(BMAX + 1);
  localparam logic [3:0]     NP4   = 4'(NUM_PPS);
  localparam logic [PWW-1:0] PW_LD = PWW'(PPS_WIDTH - 1);
  localparam logic [BPW-1:0] NP_LD = BPW'(BURST_PULSES);
  localparam logic [BHW-1:0] BH_LD = BHW'(BURST_HIGH - 1);
  localparam logic [BHW-1:0] BL_LD = BHW'(BURST_LOW - 1);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  logic [NUM_PPS-1:0] w_acc, w_miss;
  logic [7:0]         w_acc8, w_miss8;
  logic [3:0]         w_low, w_nxt_active;
  logic               w_any, w_sel_live, w_src_edge, w_sw, w_clr, w_fire, w_unused;

  logic [3:0]     r_src_sel, r_active;
  logic           r_af, r_pps, r_burst;
  logic [7:0]     r_count;
  logic [PWW-1:0] r_pw;
  state_t         r_state;
  logic [BHW-1:0] r_ph;
  logic [BPW-1:0] r_np;

  pps_select_v3_lane #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
  ) u_lane [NUM_PPS-1:0] (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_pps (pps_in_i),
    .o_acc (w_acc),
    .o_miss(w_miss)
  );

  always_comb begin
    w_acc8  = '0;
    w_miss8 = '0;
    w_acc8[NUM_PPS-1:0]  = w_acc;
    w_miss8[NUM_PPS-1:0] = w_miss;
    w_low = '0;
    w_any = 1'b0;
    for (int k = NUM_PPS - 1; k >= 0; k--) begin
      if (!w_miss8[k]) begin
        w_low = 4'(k);
        w_any = 1'b1;
      end
    end
  end

  // the configured source wins back as soon as it is healthy again
  assign w_sel_live = (r_src_sel < NP4) && !w_miss8[r_src_sel[2:0]];

  always_comb begin
    w_nxt_active = r_active;
    if (!r_af)          w_nxt_active = r_src_sel;
    else if (w_sel_live) w_nxt_active = r_src_sel;
    else if (w_any)     w_nxt_active = w_low;
  end

  assign w_src_edge = (r_active < NP4) && w_acc8[r_active[2:0]];
  assign w_sw       = wr_i & dat_i[5];
  assign w_clr      = wr_i & dat_i[6];
  assign w_fire     = (w_src_edge | w_sw) & ~r_pps;
  assign w_unused   = &{1'b0, dat_i[31:7]};

  assign pps_o       = r_pps;
  assign pps_burst_o = r_burst;
  assign dat_o       = {r_count, w_miss8, 4'b0, r_active, 3'b0, r_af, r_src_sel};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_src_sel <= '0;
      r_af      <= 1'b0;
      r_active  <= '0;
      r_count   <= '0;
      r_pps     <= 1'b0;
      r_pw      <= '0;
    end else begin
      if (wr_i) begin
        r_src_sel <= dat_i[3:0];
        r_af      <= dat_i[4];
      end
      r_active <= w_nxt_active;
      if (w_clr)       r_count <= '0;
      else if (w_fire) r_count <= r_count + 1'b1;
      if (w_fire) begin
        r_pps <= 1'b1;
        r_pw  <= PW_LD;
      end else if (r_pps) begin
        if (r_pw == '0) r_pps <= 1'b0;
        else            r_pw  <= r_pw - 1'b1;
      end
    end
  end

  // burst restarts on every pps_o rise, even mid-train
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_ph    <= '0;
      r_np    <= '0;
      r_burst <= 1'b0;
    end else if (w_fire) begin
      r_state <= S_HIGH;
      r_ph    <= BH_LD;
      r_np    <= NP_LD;
      r_burst <= 1'b1;
    end else begin
      case (r_state)
        S_HIGH: begin
          if (r_ph == '0) begin
            r_state <= S_LOW;
            r_ph    <= BL_LD;
            r_burst <= 1'b0;
          end else begin
            r_ph <= r_ph - 1'b1;
          end
        end
        S_LOW: begin
          if (r_ph == '0) begin
            r_np <= r_np - 1'b1;
            if (r_np <= 1) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_HIGH;
              r_ph    <= BH_LD;
              r_burst <= 1'b1;
            end
          end else begin
            r_ph <= r_ph - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_burst <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pps_select_v3.sv
// Scoreboard bench for pps_select_v3: stimulus queues expected pulse shapes,
// a negedge monitor captures each pps_o rise and compares.
module tb_pps_select_v3;
  localparam int NP = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr = 1'b0;
  logic [31:0]   dat_i = '0;
  logic [31:0]   dat_o;
  logic [NP-1:0] pin = '0;
  logic          pps, burst;

  pps_select_v3 #(
    .NUM_PPS(NP), .TIMEOUT_CYCLES(100), .HOLDOFF_CYCLES(10), .PPS_WIDTH(4),
    .BURST_PULSES(3), .BURST_HIGH(2), .BURST_LOW(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .wr_i(wr), .dat_i(dat_i), .dat_o(dat_o),
    .pps_in_i(pin), .pps_o(pps), .pps_burst_o(burst)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int          rise;
    logic [15:0] pps_pat;
    logic [15:0] bur_pat;
  } exp_t;
  exp_t sb[$];

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(int r, logic [15:0] pp, logic [15:0] bp);
    exp_t e;
    e.rise = r; e.pps_pat = pp; e.bur_pat = bp;
    sb.push_back(e);
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wreg(logic [31:0] d);
    wr = 1'b1; dat_i = d;
    tick();
    wr = 1'b0; dat_i = '0;
  endtask

  // software strobe: pps_o rises on the clock that samples the write
  task automatic sw_pulse(logic [31:0] extra, logic [15:0] bp);
    push_exp(cyc + 1, 16'h000F, bp);
    wreg(32'h20 | extra);
  endtask

  // monitor: 16-cycle snapshot of pps_o / pps_burst_o from each rise
  initial begin
    logic prev;
    logic [15:0] pp, bp;
    int r;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (pps && !prev) begin
        r = cyc; pp = '0; bp = '0;
        pp[0] = pps; bp[0] = burst;
        for (int i = 1; i < 16; i++) begin
          @(negedge clk);
          pp[i] = pps; bp[i] = burst;
        end
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_pulse: rise at cycle %0d, none expected", r);
        end else begin
          e = sb.pop_front();
          chk("rise_cycle", r, e.rise);
          chk("pps_shape", int'(pp), int'(e.pps_pat));
          chk("burst_shape", int'(bp), int'(e.bur_pat));
        end
      end
      prev = pps;
    end
  end

  initial begin
    int c;
    bit found;
    tick(3);
    chk("rst_dat", int'(dat_o), 0);
    chk("rst_pps", int'(pps), 0);
    chk("rst_burst", int'(burst), 0);
    rst = 1'b0;
    tick(2);

    // input 0 edge, then a second edge 5 cycles later inside holdoff
    c = cyc;
    push_exp(c + 4, 16'h000F, 16'h0333);
    pin[0] = 1'b1; tick(2); pin[0] = 1'b0; tick(3);
    pin[0] = 1'b1; tick(2); pin[0] = 1'b0;
    tick(25);
    chk("t1_count", int'(dat_o[31:24]), 1);

    // autofail: input 2 alive, input 0 goes silent
    wreg(32'h10);
    pin[2] = 1'b1; tick(3); pin[2] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (dat_o[16]) found = 1'b1;
    end
    chk("t3_miss0_set", int'(found), 1);
    chk("t3_missing", int'(dat_o[23:16]), 8'h03);
    chk("t3_active_before", int'(dat_o[11:8]), 0);
    tick();
    chk("t3_active_fail", int'(dat_o[11:8]), 2);
    push_exp(cyc + 4, 16'h000F, 16'h0333);
    pin[2] = 1'b1; tick(3); pin[2] = 1'b0;
    tick(20);
    pin[0] = 1'b1; tick(3); pin[0] = 1'b0;
    tick(3);
    chk("t3_revert", int'(dat_o[11:8]), 0);
    chk("t3_miss0_clr", int'(dat_o[16]), 0);
    chk("t3_count", int'(dat_o[31:24]), 2);
    tick(15);

    // sw strobe on the same clock as an accepted input 0 edge
    c = cyc;
    push_exp(c + 4, 16'h000F, 16'h0333);
    pin[0] = 1'b1; tick(3);
    wreg(32'h30);
    pin[0] = 1'b0;
    tick(20);
    chk("t4_count", int'(dat_o[31:24]), 3);

    // count wrap and clear-vs-increment
    wreg(32'h50);
    chk("t5_clear", int'(dat_o[31:24]), 0);
    for (int i = 0; i < 255; i++) begin
      sw_pulse(32'h10, 16'h0333);
      tick(19);
    end
    chk("t5_count255", int'(dat_o[31:24]), 255);
    sw_pulse(32'h10, 16'h0333);
    tick(19);
    chk("t5_wrap", int'(dat_o[31:24]), 0);
    sw_pulse(32'h50, 16'h0333);
    tick(19);
    chk("t5_clr_trig", int'(dat_o[31:24]), 0);

    // reset during the second burst pulse
    sw_pulse(32'h10, 16'h0013);
    tick(4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_pps", int'(pps), 0);
    chk("t6_burst", int'(burst), 0);
    chk("t6_dat", int'(dat_o), 0);
    tick(3);
    rst = 1'b0;
    tick(20);

    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
